// File: rtl/nv_ram_fifo_ctl_256x4_pkg.sv
// Shared sizing and types for the 256x4 RAM-backed FIFO controller.
package nv_ram_fifo_ctl_256x4_pkg;
    localparam int FIFO_DEPTH = 256;
    localparam int PTR_W      = 8;
    localparam int CNT_W      = 9;
    localparam int DATA_W     = 4;

    typedef logic [PTR_W-1:0]  ptr_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef struct packed {
        logic  we;
        ptr_t  wa;
        data_t di;
        logic  re;
        ptr_t  ra;
    } ram_req_t;
endpackage

// File: rtl/nv_ram_fifo_ctl_256x4_if.sv
// Write/read handshake and status bundle of the FIFO controller.
interface nv_ram_fifo_ctl_256x4_if import nv_ram_fifo_ctl_256x4_pkg::*;;
    logic  wr_pvld;
    logic  wr_prdy;
    data_t wr_pd;
    logic  rd_pvld;
    logic  rd_prdy;
    data_t rd_pd;
    cnt_t  fifo_cnt;
    logic  fifo_afull;

    modport master (output wr_pvld, wr_pd, rd_prdy,
                    input  wr_prdy, rd_pvld, rd_pd, fifo_cnt, fifo_afull);
    modport slave  (input  wr_pvld, wr_pd, rd_prdy,
                    output wr_prdy, rd_pvld, rd_pd, fifo_cnt, fifo_afull);
endinterface

// File: rtl/nv_ram_rws_256x4.sv
// 256x4 RAM: synchronous write, registered read address, combinational dout.
module nv_ram_rws_256x4 import nv_ram_fifo_ctl_256x4_pkg::*; (
    input  logic        clk,
    input  logic [31:0] pwrbus_ram_pd,
    input  ptr_t        ra,
    input  logic        re,
    output data_t       dout,
    input  ptr_t        wa,
    input  logic        we,
    input  data_t       di
);
    data_t mem [FIFO_DEPTH];
    ptr_t  ra_d;

    // Power-control bus feeds the macro's retention pins; unused in this behavioural model.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= di;
        if (re) ra_d <= ra;
    end

    assign dout = mem[ra_d];
endmodule

// File: rtl/nv_ram_fifo_ctl_256x4.sv
// FIFO controller sequencing a 256x4 registered-read-address RAM; rd_pd comes straight off the RAM.
module nv_ram_fifo_ctl_256x4 import nv_ram_fifo_ctl_256x4_pkg::*; #(
    parameter cnt_t AFULL_LVL = 9'd240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic [31:0] pwrbus_ram_pd,
    nv_ram_fifo_ctl_256x4_if.slave fifo
);
    ptr_t     wr_ptr, rd_ptr;
    cnt_t     cnt, pend, cnt_chk;
    logic     rd_vld, flush, wr_acc, pop, re;
    ram_req_t req;
    data_t    dout;

    assign flush  = rst | clr;
    assign wr_acc = fifo.wr_pvld & fifo.wr_prdy & ~flush;
    assign pop    = rd_vld & fifo.rd_prdy & ~flush;
    // Entries in the RAM that have not yet been moved onto rd_pd.
    assign pend   = cnt - cnt_t'(rd_vld);
    assign re     = (pend != '0) & (~rd_vld | fifo.rd_prdy) & ~flush;

    assign req = '{we: wr_acc, wa: wr_ptr, di: fifo.wr_pd, re: re, ra: rd_ptr};

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            rd_vld <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ptr_t'(1);
            if (re)     rd_ptr <= rd_ptr + ptr_t'(1);
            case ({wr_acc, pop})
                2'b10:   cnt <= cnt + cnt_t'(1);
                2'b01:   cnt <= cnt - cnt_t'(1);
                default: cnt <= cnt;
            endcase
            if (re)       rd_vld <= 1'b1;
            else if (pop) rd_vld <= 1'b0;
        end
    end

    nv_ram_rws_256x4 u_ram (
        .clk           (clk),
        .pwrbus_ram_pd (pwrbus_ram_pd),
        .ra            (req.ra),
        .re            (req.re),
        .dout          (dout),
        .wa            (req.wa),
        .we            (req.we),
        .di            (req.di)
    );

    assign fifo.wr_prdy    = (cnt != cnt_t'(FIFO_DEPTH));
    assign fifo.rd_pvld    = rd_vld;
    assign fifo.rd_pd      = dout;
    assign fifo.fifo_cnt   = cnt;
    assign fifo.fifo_afull = (cnt >= AFULL_LVL);

    assign cnt_chk = cnt + cnt_t'(wr_acc) - cnt_t'(pop);

    a_wr_prdy: assert property (@(posedge clk) disable iff (rst)
        fifo.wr_prdy == (cnt != cnt_t'(FIFO_DEPTH)));
    a_rd_hold: assert property (@(posedge clk) disable iff (rst)
        (rd_vld & ~fifo.rd_prdy & ~clr) |=> $stable(fifo.rd_pd));
    a_cnt_upd: assert property (@(posedge clk) disable iff (rst)
        ~clr |=> cnt == $past(cnt_chk));
    a_cnt_max: assert property (@(posedge clk) disable iff (rst)
        cnt <= cnt_t'(FIFO_DEPTH));
    // Producer must hold its data while stalled.
    a_wr_hold: assert property (@(posedge clk) disable iff (rst)
        (fifo.wr_pvld & ~fifo.wr_prdy) |=> (~fifo.wr_pvld | $stable(fifo.wr_pd)));
endmodule
